// File: rtl/adder_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package adder_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

endpackage

// File: rtl/byte_slice_adder.sv
// Combinational 8-bit ripple-carry slice built from per-bit full-adder cells.
module byte_slice_adder
    import adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic [BYTE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[BYTE_W];

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial wide adder: one byte per cycle through a shared 8-bit slice,
// carry held in a register between cycles, valid/ready on both sides.
module multibyte_add_seq
    import adder_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int unsigned W     = BYTE_W * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    add_state_t        state, next_state;
    logic [IDX_W-1:0]  idx;
    logic [W-1:0]      a_q, b_q;
    logic              carry;
    logic              accept_c, step_c, last_c;
    logic [BYTE_W-1:0] slice_s;
    logic              slice_co;

    byte_slice_adder u_slice (
        .a  (a_q[BYTE_W*idx +: BYTE_W]),
        .b  (b_q[BYTE_W*idx +: BYTE_W]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and datapath strobes
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        step_c     = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c   = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (idx == IDX_LAST) begin
                    last_c     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake flags registered from the upcoming state so reset drives both low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
        end
    end

    // Operand capture and byte-serial accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept_c) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (step_c) begin
            sum[BYTE_W*idx +: BYTE_W] <= slice_s;
            carry                     <= slice_co;
            if (last_c) begin
                cout <= slice_co;
                ovf  <= (a_q[W-1] == b_q[W-1]) && (slice_s[BYTE_W-1] != a_q[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
